// File: rtl/dmem_lsu_if.sv
// Core-request and RAM-port bundle for the load/store unit.
// Signal names keep the LSU's own direction suffixes; slave = LSU, master = core/RAM side.
interface dmem_lsu_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid_i;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [31:0]       req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              stall_o;
   logic [31:0]       rdata_o;
   logic              rdata_valid_o;
   logic              misalign_o;
   logic              ram_en_o;
   logic              ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [31:0]       ram_wdata_o;
   logic [31:0]       ram_rdata_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  ram_rdata_i,
      output stall_o, rdata_o, rdata_valid_o, misalign_o,
      output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output ram_rdata_i,
      input  stall_o, rdata_o, rdata_valid_o, misalign_o,
      input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o
   );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store unit for a word-wide RAM without byte enables.
// Sub-word stores use read-modify-write; loads are sign/zero extended.
module dmem_lsu #(
   parameter int ADDR_W = 10
) (
   input  logic        clk_i,
   input  logic        rst_i,
   dmem_lsu_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RD, DONE} state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              misaligned;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^{bus.req_addr_i[31:ADDR_W+2]};

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      r = word;
      if (size == 2'b00) begin
         if (uns) r = {24'd0, b};
         else     r = 32'(b);
      end else if (size == 2'b01) begin
         if (uns) r = {16'd0, h};
         else     r = 32'(h);
      end
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic [15:0] wd);
      logic [31:0] r;
      r = word;
      if (size == 2'b00) begin
         case (off)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end else if (off[1]) begin
         r[31:16] = wd;
      end else begin
         r[15:0] = wd;
      end
      return r;
   endfunction

   always_comb begin
      misaligned = (bus.req_size_i == 2'b11) ||
                   (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                   (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
      state_d           = state_q;
      we_d              = we_q;
      size_d            = size_q;
      uns_d             = uns_q;
      off_d             = off_q;
      wdata_d           = wdata_q;
      waddr_d           = waddr_q;
      rdata_d           = rdata_q;
      bus.stall_o       = 1'b0;
      bus.rdata_valid_o = 1'b0;
      bus.misalign_o    = 1'b0;
      bus.ram_en_o      = 1'b0;
      bus.ram_we_o      = 1'b0;
      bus.ram_addr_o    = waddr_q;
      bus.ram_wdata_o   = 32'd0;
      case (state_q)
         IDLE: begin
            bus.ram_addr_o = bus.req_addr_i[ADDR_W+1:2];
            if (bus.req_valid_i) begin
               if (misaligned) begin
                  bus.misalign_o = 1'b1;
               end else begin
                  // Only the low half of store data is needed after acceptance;
                  // word stores complete in this cycle.
                  we_d         = bus.req_we_i;
                  size_d       = bus.req_size_i;
                  uns_d        = bus.req_unsigned_i;
                  off_d        = bus.req_addr_i[1:0];
                  wdata_d      = bus.req_wdata_i[15:0];
                  waddr_d      = bus.req_addr_i[ADDR_W+1:2];
                  bus.stall_o  = 1'b1;
                  bus.ram_en_o = 1'b1;
                  if (bus.req_we_i && bus.req_size_i == 2'b10) begin
                     bus.ram_we_o    = 1'b1;
                     bus.ram_wdata_o = bus.req_wdata_i;
                     state_d         = DONE;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            bus.stall_o = 1'b1;
            if (we_q) begin
               bus.ram_en_o    = 1'b1;
               bus.ram_we_o    = 1'b1;
               bus.ram_wdata_o = store_merge(bus.ram_rdata_i, size_q, off_q, wdata_q);
            end else begin
               rdata_d = load_extend(bus.ram_rdata_i, size_q, off_q, uns_q);
            end
            state_d = DONE;
         end
         DONE: begin
            bus.rdata_valid_o = !we_q;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst_i) begin
         bus.stall_o       = 1'b0;
         bus.rdata_valid_o = 1'b0;
         bus.misalign_o    = 1'b0;
         bus.ram_en_o      = 1'b0;
         bus.ram_we_o      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         wdata_q <= 16'd0;
         waddr_q <= '0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed bench for dmem_lsu against a byte-addressed reference memory.
module tb_dmem_lsu;
   localparam int AW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_lsu_if #(.ADDR_W(AW)) bus();
   dmem_lsu #(.ADDR_W(AW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   // Word RAM seen by the DUT, one-cycle read latency.
   logic [31:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.ram_en_o) begin
         if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_wdata_o;
         else              bus.ram_rdata_i     <= ram[bus.ram_addr_o];
      end
   end

   // Reference: plain little-endian byte memory.
   logic [7:0] refm [0:(4<<AW)-1];
   int n_pass = 0;
   int n_total = 0;

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] addr);
      if (sz == 2'd3) return 1'b1;
      return (int'(addr[3:0]) % nbytes(sz)) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      int n, base;
      n = nbytes(sz);
      base = int'(addr[AW+1:0]);
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(refm[base+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
      int base;
      base = int'(addr[AW+1:0]);
      for (int i = 0; i < nbytes(sz); i++) refm[base+i] = wd[8*i +: 8];
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]};
   endfunction

   // Presents one request, holds it while stalled, and releases it after the completing cycle.
   task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int stalls, output int wr,
                         output int rdv_n, output logic en0, output logic mis0, output int cyc);
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = sz;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wd;
      rd = 32'd0; stalls = 0; wr = 0; rdv_n = 0; en0 = 1'b0; mis0 = 1'b0; cyc = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (c == 0) begin en0 = bus.ram_en_o; mis0 = bus.misalign_o; end
         if (bus.ram_en_o && bus.ram_we_o) wr++;
         if (bus.rdata_valid_o) begin rd = bus.rdata_o; rdv_n++; end
         cyc = c + 1;
         if (!bus.stall_o) begin
            @(negedge clk);
            break;
         end
         stalls++;
         @(negedge clk);
      end
      bus.req_valid_i = 1'b0;
      if (we && !is_mis(sz, addr)) ref_store(addr, sz, wd);
   endtask

   logic [31:0] rd;
   int stalls, wr, rdv_n, cyc;
   logic en0, mis0;

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h8; bus.req_wdata_i = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if ({bus.stall_o, bus.ram_en_o, bus.ram_we_o, bus.rdata_valid_o} !== 4'b0000) $display("FAIL reset_outputs: stall/en/we/rdv=%b required 0000", {bus.stall_o, bus.ram_en_o, bus.ram_we_o, bus.rdata_valid_o});
      else n_pass++;
      bus.req_addr_i = 32'h6;
      #1;
      n_total++;
      if (bus.misalign_o !== 1'b0) $display("FAIL reset_misalign: got %b required 0", bus.misalign_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      #1;
      n_total++;
      if (bus.rdata_o !== 32'd0) $display("FAIL reset_rdata: got %h required 00000000", bus.rdata_o);
      else n_pass++;
      n_total++;
      if ({bus.stall_o, bus.ram_en_o, bus.misalign_o, bus.rdata_valid_o} !== 4'b0000) $display("FAIL idle_outputs: got %b required 0000", {bus.stall_o, bus.ram_en_o, bus.misalign_o, bus.rdata_valid_o});
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_loads();
      logic [1:0]  szs  [5] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
      logic        unss [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] adrs [5] = '{32'h8, 32'h12, 32'h12, 32'h12, 32'h12};
      logic [31:0] exps [5] = '{32'h12345678, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h000080F0};
      for (int i = 0; i < 5; i++) begin
         run_op(1'b0, szs[i], unss[i], adrs[i], 32'h0, rd, stalls, wr, rdv_n, en0, mis0, cyc);
         n_total++;
         if (rd !== exps[i] || rdv_n != 1) $display("FAIL load_%0d: data %h valid_cycles %0d required %h 1", i, rd, rdv_n, exps[i]);
         else n_pass++;
         n_total++;
         if (stalls != 2 || cyc != 3 || wr != 0) $display("FAIL load_latency_%0d: stalls %0d cycles %0d writes %0d required 2 3 0", i, stalls, cyc, wr);
         else n_pass++;
      end
   endtask

   task automatic test_subword_store();
      run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AB, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (ram[4] !== 32'h80F0AB34 || stalls != 2 || wr != 1 || rdv_n != 0) $display("FAIL sb_rmw: word %h stalls %0d writes %0d rdv %0d required 80f0ab34 2 1 0", ram[4], stalls, wr, rdv_n);
      else n_pass++;
      run_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h5555BEEF, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (ram[4] !== 32'hBEEFAB34 || stalls != 2 || wr != 1) $display("FAIL sh_rmw: word %h stalls %0d writes %0d required beefab34 2 1", ram[4], stalls, wr);
      else n_pass++;
      n_total++;
      if (bus.rdata_o !== 32'h000080F0) $display("FAIL rdata_hold: got %h required 000080f0", bus.rdata_o);
      else n_pass++;
   endtask

   task automatic test_word_store();
      run_op(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (stalls != 1 || cyc != 2 || wr != 1 || ram[2] !== 32'hDEADBEEF) $display("FAIL sw: stalls %0d cycles %0d writes %0d word %h required 1 2 1 deadbeef", stalls, cyc, wr, ram[2]);
      else n_pass++;
      run_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (rd !== 32'hDEADBEEF) $display("FAIL sw_readback: got %h required deadbeef", rd);
      else n_pass++;
   endtask

   task automatic test_misalign();
      logic [1:0]  szs  [3] = '{2'd2, 2'd1, 2'd3};
      logic [31:0] adrs [3] = '{32'h6, 32'h13, 32'h8};
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, szs[i], 1'b0, adrs[i], 32'h0, rd, stalls, wr, rdv_n, en0, mis0, cyc);
         n_total++;
         if (mis0 !== 1'b1 || stalls != 0 || en0 !== 1'b0 || rdv_n != 0) $display("FAIL misalign_%0d: mis %b stalls %0d en %b rdv %0d required 1 0 0 0", i, mis0, stalls, en0, rdv_n);
         else n_pass++;
      end
      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (rd !== 32'hBEEFAB34 || stalls != 2) $display("FAIL after_misalign: data %h stalls %0d required beefab34 2", rd, stalls);
      else n_pass++;
   endtask

   task automatic test_reset_in_rd();
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd0;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h9; bus.req_wdata_i = 32'h5A;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if (bus.ram_en_o !== 1'b0 || bus.stall_o !== 1'b0) $display("FAIL rst_in_rd_outputs: en %b stall %b required 0 0", bus.ram_en_o, bus.stall_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid_i = 1'b0;
      #1;
      n_total++;
      if (ram[2] !== 32'hDEADBEEF || bus.rdata_o !== 32'd0) $display("FAIL rst_in_rd_state: word %h rdata %h required deadbeef 00000000", ram[2], bus.rdata_o);
      else n_pass++;
      @(negedge clk);
      run_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (rd !== 32'hDEADBEEF || stalls != 2) $display("FAIL rst_in_rd_recover: data %h stalls %0d required deadbeef 2", rd, stalls);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd1;
      run_op(1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h80F01234, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      run_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd1, stalls, wr, rdv_n, en0, mis0, cyc);
      run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, stalls, wr, rdv_n, en0, mis0, cyc);
      n_total++;
      if (rd1 !== 32'h12345678 || rd !== 32'h80F01234) $display("FAIL b2b_data: got %h %h required 12345678 80f01234", rd1, rd);
      else n_pass++;
      n_total++;
      if (en0 !== 1'b1 || stalls != 2 || cyc != 3) $display("FAIL b2b_accept: en %b stalls %0d cycles %0d required 1 2 3", en0, stalls, cyc);
      else n_pass++;
   endtask

   task automatic test_random();
      logic        we, uns, mis;
      logic [1:0]  sz;
      logic [31:0] addr, wd, exp;
      for (int i = 0; i < 60; i++) begin
         we   = 1'($urandom_range(0, 1));
         sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         uns  = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 63));
         wd   = $urandom;
         mis  = is_mis(sz, addr);
         exp  = ref_load(addr, sz, uns);
         run_op(we, sz, uns, addr, wd, rd, stalls, wr, rdv_n, en0, mis0, cyc);
         n_total++;
         if (mis) begin
            if (mis0 !== 1'b1 || stalls != 0 || en0 !== 1'b0 || wr != 0) $display("FAIL rand_mis_%0d: mis %b stalls %0d en %b writes %0d required 1 0 0 0", i, mis0, stalls, en0, wr);
            else n_pass++;
         end else if (!we) begin
            if (rd !== exp || stalls != 2 || rdv_n != 1) $display("FAIL rand_load_%0d: data %h stalls %0d required %h 2", i, rd, stalls, exp);
            else n_pass++;
         end else begin
            if (ram[addr[AW+1:2]] !== ref_word(int'(addr[AW+1:2])) || wr != 1 || stalls != ((sz == 2'd2) ? 1 : 2))
               $display("FAIL rand_store_%0d: word %h stalls %0d writes %0d required %h %0d 1", i, ram[addr[AW+1:2]], stalls, wr, ref_word(int'(addr[AW+1:2])), (sz == 2'd2) ? 1 : 2);
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
      for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'd0;
      for (int i = 0; i < (4<<AW); i++) refm[i] = 8'd0;
      ram[2] <= 32'h12345678;
      ram[4] <= 32'h80F01234;
      ref_store(32'h8, 2'd2, 32'h12345678);
      ref_store(32'h10, 2'd2, 32'h80F01234);
      @(negedge clk);
      test_reset();
      test_loads();
      test_subword_store();
      test_word_store();
      test_misalign();
      test_reset_in_rd();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly downstream of `sc_datapath`'s data-memory port. It performs RV32I byte, halfword and word accesses against a word-wide synchronous RAM with no byte enables. Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. The unit stalls the core until each access completes and flags misaligned or illegal requests.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address width (depth 2^ADDR_W words).

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  core presents a memory instruction.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned_i`  in  1  funct3[2]; selects zero-extension for loads.
- `req_addr_i`  in  32  byte address (`dmem_addr_o` of core).
- `req_wdata_i`  in  32  store data (`dmem_in_o` of core); low bits used for sub-word.
- `stall_o`  out  1  core must hold PC and request while high.
- `rdata_o`  out  32  extended load result (to core `dmem_out_i`).
- `rdata_valid_o`  out  1  `rdata_o` carries a fresh load result this cycle.
- `misalign_o`  out  1  current request misaligned or illegal size.
- `ram_en_o`  out  1  RAM access strobe.
- `ram_we_o`  out  1  RAM write (with `ram_en_o`).
- `ram_addr_o`  out  ADDR_W  word address = `req_addr_i[ADDR_W+1:2]`; upper bits ignored.
- `ram_wdata_o`  out  32  RAM write word.
- `ram_rdata_i`  in  32  RAM read word, valid the cycle after a read strobe.

## Operation
- FSM states: IDLE, RD, DONE.
- Misaligned means: half with addr[0]=1; word with addr[1:0]≠00; or size=11.
  - Evaluated combinationally in IDLE.
  - `misalign_o`=1, `stall_o`=0, no RAM strobe, `rdata_valid_o`=0.
  - Stay in IDLE.
- IDLE with valid, aligned request:
  - Latch we, size, unsigned, byte offset, wdata and word address.
  - Drive `ram_en_o`=1 combinationally from the request.
  - Word store: `ram_we_o`=1, `ram_wdata_o`=`req_wdata_i`, go to DONE.
  - Load or sub-word store: `ram_we_o`=0, go to RD.
- RD, load:
  - Extract the byte or half at the latched offset from `ram_rdata_i`.
  - Sign-extend, or zero-extend if unsigned; register into `rdata_o`.
  - Go to DONE.
- RD, sub-word store:
  - `ram_en_o`=`ram_we_o`=1, same word address.
  - `ram_wdata_o` = `ram_rdata_i` with the target byte or half replaced by `req_wdata_i[7:0]` or `[15:0]`.
  - Go to DONE.
- DONE:
  - `stall_o`=0.
  - `rdata_valid_o`=1 only if the operation was a load.
  - Go to IDLE unconditionally. The core advances on this edge.
- `stall_o` = `req_valid_i` && !misaligned && state≠DONE (includes the IDLE acceptance cycle).
- Request inputs changing after acceptance are ignored; the latched copy is used.
- `rdata_o` holds the last load result until the next load completes.

## Timing
- Reset values: state IDLE, `rdata_o`=0, all latches 0.
- While `rst_i`=1, force `ram_en_o`, `ram_we_o`, `stall_o`, `rdata_valid_o` and `misalign_o` to 0.
- Latency from acceptance to the DONE cycle, inclusive:
  - word store: 2 cycles (1 stall);
  - load: 3 cycles (2 stall);
  - sub-word store: 3 cycles (2 stall).
- RAM read data is consumed exactly one cycle after the read strobe. No RAM wait states exist.
- Reset in RD:
  - Return to IDLE next edge; no write is issued.
  - `rdata_o` is cleared to 0, and memory is unchanged.
- `req_valid_i`=0 in IDLE: all RAM and core outputs inactive; `rdata_o` holds.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after DONE. There are no bubbles beyond the FSM.
- Sign extension uses bit 7 (byte) or bit 15 (half) of the extracted field. Unsigned loads zero bits 31:8 or 31:16.

## Test plan
All scenarios use a RAM model where word 2 (addr 0x8) = 0x12345678 and word 4 (addr 0x10) = 0x80F01234.
- lw 0x8:
  - stall high 2 cycles;
  - DONE cycle: `rdata_o`=0x12345678, `rdata_valid_o`=1.
- Loads from 0x12 (byte 0xF0, half 0x80F0):
  - lb 0x12 -> 0xFFFFFFF0;
  - lbu 0x12 -> 0x000000F0;
  - lh 0x12 -> 0xFFFF80F0;
  - lhu 0x12 -> 0x000080F0.
- Sub-word stores:
  - sb 0xAB to 0x11 -> read then write; word 4 becomes 0x80F0AB34.
  - sh 0xBEEF to 0x12 -> word 4 becomes 0xBEEFAB34.
- sw 0xDEADBEEF to 0x8:
  - single write strobe in the acceptance cycle, `stall_o` high 1 cycle;
  - readback with lw 0x8 -> 0xDEADBEEF.
- Misaligned and illegal requests:
  - lw 0x6, lh 0x13 and size=11 each -> `misalign_o`=1, `stall_o`=0, `ram_en_o`=0, FSM stays IDLE.
- Reset and back-to-back:
  - sb issued, then `rst_i`=1 in RD -> no write strobe, word unchanged, IDLE after reset.
  - Back-to-back lw 0x8 then lw 0x10 -> second accepted the cycle after first DONE; results 0x12345678 then 0x80F01234.
